// File: rtl/sp_loader.sv
// rtl/sp_loader.sv - serial-to-parallel loader feeding an n-bit load register, LSB first.
// Optional even-parity bit after each word when SP_PARITY_EN is defined.
module sp_loader #(
  parameter int n = 4
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         abort,
  output logic [n-1:0] d,
  output logic         load,
  output logic         busy,
  output logic         perr,
  output logic [7:0]   words
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

`ifdef SP_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [n-1:0]  sr_q;
  logic [n-1:0]  sr_d;
  logic [n-1:0]  d_q;
  logic          load_q;
  logic          busy_q;
  logic          perr_q;
  logic [7:0]    words_q;
  logic          accept;

  // In IDLE cnt_q and sr_q are zero, so the same insert covers the first bit.
  always_comb begin
    sr_d = sr_q;
    sr_d[cnt_q] = sin;
  end

  assign accept = sin_valid && !abort;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      d_q     <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      words_q <= 8'd0;
    end else begin
      load_q <= 1'b0;
      perr_q <= 1'b0;
      // Stays high through the cycle that follows the completing or abort edge.
      busy_q <= (state_q != IDLE) || accept;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sr_q    <= '0;
      end else if (sin_valid) begin
        case (state_q)
          IDLE: begin
            sr_q    <= sr_d;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
          SHIFT: begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
`ifdef SP_PARITY_EN
              sr_q    <= sr_d;
              state_q <= PAR;
`else
              sr_q    <= '0;
              d_q     <= sr_d;
              load_q  <= 1'b1;
              words_q <= words_q + 8'd1;
              state_q <= IDLE;
`endif
            end else begin
              sr_q  <= sr_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
`ifdef SP_PARITY_EN
          PAR: begin
            if ((^sr_q) == sin) begin
              d_q     <= sr_q;
              load_q  <= 1'b1;
              words_q <= words_q + 8'd1;
            end else begin
              perr_q <= 1'b1;
            end
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
`endif
          default: begin
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign d     = d_q;
  assign load  = load_q;
  assign busy  = busy_q;
  assign perr  = perr_q;
  assign words = words_q;

endmodule

// File: tb/tb_sp_loader.sv
// tb/tb_sp_loader.sv - randomized bench for sp_loader against a queue-based word model.
module tb_sp_loader;

  localparam int N = 4;
`ifdef SP_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] d;
  logic         load;
  logic         busy;
  logic         perr;
  logic [7:0]   words;

  sp_loader #(.n(N)) dut (
    .ck(ck), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .d(d), .load(load), .busy(busy), .perr(perr), .words(words)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int busy_cnt = 0;
  int load_cnt = 0;
  int last_load_cyc = 0;
  int prev_load_cyc = 0;

  // Model: the bits of the word in progress, plus what the outputs must show.
  bit           mq[$];
  logic [N-1:0] m_d = '0;
  logic         m_load = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_perr = 1'b0;
  logic [7:0]   m_words = 8'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_d = '0; m_load = 0; m_busy = 0; m_perr = 0; m_words = 0;
  endtask

  task automatic model_edge(input bit v, input bit b, input bit a);
    logic [N-1:0] w;
    m_busy = (mq.size() != 0) || (v && !a);
    m_load = 0;
    m_perr = 0;
    if (a) mq.delete();
    else if (v) begin
      mq.push_back(b);
      if (mq.size() == NB) begin
        w = '0;
        for (int i = 0; i < N; i++) w[i] = mq[i];
`ifdef SP_PARITY_EN
        if ((^w) == mq[N]) begin
          m_d = w; m_load = 1; m_words = m_words + 8'd1;
        end else m_perr = 1;
`else
        m_d = w; m_load = 1; m_words = m_words + 8'd1;
`endif
        mq.delete();
      end
    end
  endtask

  always @(negedge ck) begin
    cyc++;
    if (chk_en) begin
      check("d", d, m_d);
      check("load", load, m_load);
      check("busy", busy, m_busy);
      check("perr", perr, m_perr);
      check("words", words, m_words);
    end
    if (busy) busy_cnt++;
    if (load) begin
      load_cnt++;
      prev_load_cyc = last_load_cyc;
      last_load_cyc = cyc;
    end
  end

  task automatic step(input bit v, input bit b, input bit a);
    sin_valid = v; sin = b; abort = a;
    @(posedge ck);
    model_edge(v, b, a);
    @(negedge ck);
    #1;
    sin_valid = 0; sin = 0; abort = 0;
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) step(1, w[i], 0);
`ifdef SP_PARITY_EN
    step(1, ^w, 0);
`endif
  endtask

  int lc;
  logic [7:0] wsave;
  logic [N-1:0] dsave;

  initial begin
    #1;
    check("rst_d", d, 0);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_perr", perr, 0);
    check("rst_words", words, 0);
    #20;
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    step(0, 0, 0);

    // Basic word 1,0,1,1 -> 1101
    busy_cnt = 0;
    send_word(4'b1101);
    check("basic_load", load, 1);
    check("basic_d", d, 4'b1101);
    check("basic_words", words, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("basic_busy_cycles", busy_cnt, NB);

    // Gaps of 3 idle cycles between bits
    load_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      step(1, (i < N) ? bit'((4'b1101 >> i) & 1) : bit'(^4'b1101), 0);
      if (i < NB - 1) begin
        for (int j = 0; j < 3; j++) step(0, 0, 0);
        check("gap_no_early_load", load_cnt, 0);
      end
    end
    check("gap_load", load, 1);
    check("gap_d", d, 4'b1101);
    step(0, 0, 0);

    // Back-to-back 0011 then 0100
    load_cnt = 0;
    send_word(4'b0011);
    check("b2b_d1", d, 4'b0011);
    send_word(4'b0100);
    check("b2b_d2", d, 4'b0100);
    check("b2b_loads", load_cnt, 2);
    check("b2b_spacing", last_load_cyc - prev_load_cyc, NB);
    step(0, 0, 0);

    // Abort after two bits
    wsave = words; dsave = d; lc = load_cnt;
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    check("abort_busy", busy, 0);
    check("abort_d", d, dsave);
    check("abort_words", words, wsave);
    check("abort_noload", load_cnt, lc);

    // Abort together with the final bit
    for (int i = 0; i < NB - 1; i++) step(1, 1, 0);
    step(1, 1, 1);
    check("abort_last_load", load, 0);
    step(0, 0, 0);
    check("abort_last_words", words, wsave);

`ifdef SP_PARITY_EN
    for (int i = 0; i < N; i++) step(1, bit'((4'b0111 >> i) & 1), 0);
    step(1, 1, 0);
    check("par_ok_load", load, 1);
    check("par_ok_d", d, 4'b0111);
    for (int i = 0; i < N; i++) step(1, bit'((4'b1000 >> i) & 1), 0);
    step(1, 0, 0);
    check("par_bad_perr", perr, 1);
    check("par_bad_load", load, 0);
    check("par_bad_d", d, 4'b0111);
    step(0, 0, 0);
`endif

    // Reset mid-stream, no clock needed
    step(1, 1, 0);
    step(1, 1, 0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_d", d, 0);
    check("midrst_load", load, 0);
    check("midrst_words", words, 0);
    model_reset();
    @(negedge ck);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(0, 0, 0);

    // 256 consecutive random words: counter wraps
    for (int k = 0; k < 256; k++) begin
      send_word(N'($urandom));
      if (k == 254) check("wrap_255", words, 8'd255);
    end
    check("wrap_0", words, 8'd0);
    step(0, 0, 0);

    // Random traffic with occasional aborts and gaps
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31) == 0);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_loader.md
# sp_loader

Serial-to-parallel loader sitting directly upstream of the n-bit load register `r`. Accepts a bit stream one bit per qualified clock, assembles n-bit words LSB first, and presents each completed word on `d` together with a one-cycle `load` pulse. `d` and `load` connect straight to the register's `d` and `load` inputs. A running count of delivered words supports bring-up and test.

## Interface
Parameters:
- `n`, default 4, word width; must be ≥ 2.

Ports:
- `ck`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sin`  input  1  serial data bit.
- `sin_valid`  input  1  `sin` is sampled on the rising edge while this is high.
- `abort`  input  1  synchronous abort; discards any partial word.
- `d`  output  n  last completed word; drives the register's data input.
- `load`  output  1  one-cycle pulse marking that `d` holds a new word.
- `busy`  output  1  a partial word is held (state is not IDLE).
- `perr`  output  1  one-cycle pulse on a parity mismatch; constant 0 without `SP_PARITY_EN`.
- `words`  output  8  number of words delivered; wraps from 255 to 0.

## Operation
- **States:** IDLE, SHIFT, and PAR (PAR exists only with `SP_PARITY_EN`).
- **Internal state:** n-bit shift register `sr`; bit counter `cnt` of width ceil(log2 n); all outputs are registered.
- **IDLE:** on `sin_valid`=1, capture `sin` into `sr[0]`, set `cnt`=1, go to SHIFT.
- **SHIFT:** on each `sin_valid`=1, write `sin` into `sr[cnt]` and increment `cnt`. Cycles with `sin_valid`=0 hold state; there is no timeout.
- **Word complete:** on the edge that accepts bit `cnt`=n-1:
  - without parity: `d` gets the assembled word, `load` is set to 1, `words` increments, and the state goes to IDLE;
  - with parity: go to PAR instead.
- **PAR:** the next valid bit is the even-parity bit, expected to equal the XOR of the n data bits.
  - Match: update `d`, pulse `load`, increment `words`, go to IDLE.
  - Mismatch: `d` unchanged, no `load`, pulse `perr`, go to IDLE.
- **Back-to-back words:** a `sin_valid` in the cycle after completion starts a new word from IDLE. No idle gap is required.
- **Output hold:** `d` holds its value between loads and never shows partial words.
- **Abort:** `abort`=1 on an edge forces IDLE and clears `cnt` and `sr`. `d` and `words` are unchanged, and `load` and `perr` are 0 on the next cycle.
  - If `abort` and `sin_valid` are high together, abort wins and the bit is dropped.
  - An abort on the final-bit edge suppresses that load.
- **Reset mid-word:** the partial word is lost and no `load` is produced.

## Timing
- **Reset values:** `d`=0, `load`=0, `busy`=0, `perr`=0, `words`=0, state IDLE, `cnt`=0, `sr`=0.
- **Load latency:** `load` and the new `d` are high/valid in the cycle immediately after the edge that sampled the last data bit (or the parity bit). The downstream register captures `d` on the following edge.
- **Pulse width:** `load` and `perr` are exactly one cycle wide. For consecutive words they are separated by at least n-1 cycles without parity, or n cycles with parity.
- **`busy`:** rises the cycle after the first bit is accepted. It falls the cycle after the completing edge or the abort edge.
- **Throughput:** one word per n valid cycles, or n+1 with parity.

## Configuration
- **`SP_PARITY_EN` defined:** PAR state and parity check are present, as described above.
- **`SP_PARITY_EN` undefined:**
  - PAR state, parity logic and checking are removed;
  - `perr` is tied to 0;
  - a word completes on the n-th valid bit.

## Test plan
All scenarios use n=4.
- **Reset:** reset low mid-stream → all outputs 0 and `busy`=0 immediately, with no clock needed.
- **Basic word:** send bits 1,0,1,1 with `sin_valid`=1 on consecutive edges, no parity → one-cycle `load`, `d`=4'b1101, `words`=1, and `busy` high for exactly 4 cycles.
- **Gaps and back-to-back:**
  - `sin_valid` gaps of 3 cycles between bits → same `d`=4'b1101 with no early `load`;
  - 4'b0011 immediately followed by 4'b0100 → two `load` pulses 4 cycles apart, `d` sequence 0011 then 0100.
- **Abort:**
  - `abort` after 2 bits → `busy` falls, no `load`, `d` keeps its previous value, `words` unchanged;
  - `abort` together with the 4th bit → no `load`.
- **Parity (with `SP_PARITY_EN`):**
  - data 4'b0111 with parity 1 → `load`, `d`=0111;
  - parity 0 → `perr` pulse, no `load`, `d` unchanged.
- **Counter wrap:** 256 consecutive words → `words` wraps to 0, and every word's `load` coincides with the correct `d`.
